// File: rtl/seq_det_logger.sv
// Timestamped event logger for an upstream sequence detector.
// A free-running counter stamps each det pulse; stamps are queued in a small
// FIFO and drained by a ready-driven consumer. Events are dropped on overflow
// unless a pop frees a slot in the same cycle.
// Optional feature: define SEQ_LOG_DROPCNT_EN to add a saturating drop counter.
module seq_det_logger #(
  parameter int unsigned TS_W  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       det,
  input  logic                       out_ready,
  input  logic                       clr_ovf,
  output logic                       out_valid,
  output logic [TS_W-1:0]            out_ts,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
`ifdef SEQ_LOG_DROPCNT_EN
  output logic [7:0]                 drop_cnt,
`endif
  output logic [7:0]                 evt_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [TS_W-1:0] ts_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q;
  logic            ovf_q;
  logic [7:0]      evt_cnt_q;
  logic [TS_W-1:0] mem_q [DEPTH];

  logic push, pop, drop;

  // Handshake decode; a pop frees a slot so a full FIFO can still accept.
  always_comb begin
    pop  = (level_q != '0) & out_ready;
    push = det & ((level_q < LvlW'(DEPTH)) | pop);
    drop = det & ~push;
  end

  // Free-running timestamp, pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      evt_cnt_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      level_q <= level_q + LvlW'(1);
      else if (pop && !push) level_q <= level_q - LvlW'(1);
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
      if (push && evt_cnt_q != 8'hFF) evt_cnt_q <= evt_cnt_q + 8'd1;
    end
  end

  // Stamp storage; deliberately not reset, contents are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ts_q;
  end

`ifdef SEQ_LOG_DROPCNT_EN
  logic [7:0] drop_cnt_q;

  // Saturating count of dropped events; unaffected by clr_ovf.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  // Outputs come straight from registered state; head stamp read from storage.
  always_comb begin
    out_valid = (level_q != '0);
    out_ts    = mem_q[rd_ptr_q];
    level     = level_q;
    ovf       = ovf_q;
    evt_cnt   = evt_cnt_q;
  end

endmodule

// File: tb/tb_seq_det_logger.sv
// Self-checking bench for seq_det_logger: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_seq_det_logger;

  localparam int unsigned TS_W  = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             det;
  logic             out_ready;
  logic             clr_ovf;
  logic             out_valid;
  logic [TS_W-1:0]  out_ts;
  logic [LVL_W-1:0] level;
  logic             ovf;
  logic [7:0]       evt_cnt;
`ifdef SEQ_LOG_DROPCNT_EN
  logic [7:0]       drop_cnt;
`endif

  seq_det_logger #(
    .TS_W  (TS_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .det       (det),
    .out_ready (out_ready),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_ts    (out_ts),
    .level     (level),
    .ovf       (ovf),
`ifdef SEQ_LOG_DROPCNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .evt_cnt   (evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_ts;
  int m_q[$];
  bit m_ovf;
  int m_evt;
  int m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ts   = 0;
    m_q    = {};
    m_ovf  = 1'b0;
    m_evt  = 0;
    m_drop = 0;
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("level", 32'(level), 32'(m_q.size()));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("evt_cnt", 32'(evt_cnt), 32'(m_evt));
    if (m_q.size() != 0) check("out_ts", 32'(out_ts), 32'(m_q[0]));
`ifdef SEQ_LOG_DROPCNT_EN
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  // Drive one cycle of inputs (called just after a falling edge), advance the
  // model by the same cycle, then compare on the next falling edge.
  task automatic step(input bit d, input bit r, input bit c);
    bit do_pop, do_push;
    det       = d;
    out_ready = r;
    clr_ovf   = c;
    do_pop  = (m_q.size() != 0) && r;
    do_push = d && ((m_q.size() < DEPTH) || do_pop);
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      m_q.push_back(m_ts);
      if (m_evt < 255) m_evt++;
    end
    if (d && !do_push) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end else if (c) begin
      m_ovf = 1'b0;
    end
    m_ts = (m_ts + 1) % (1 << TS_W);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    det       = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    rst       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b1;
  endtask

  task automatic drain_all();
    int guard = 0;
    while (m_q.size() != 0 && guard < 32) begin
      step(1'b0, 1'b1, 1'b0);
      guard++;
    end
  endtask

  initial begin
    int t;
    rst       = 1'b0;
    det       = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    model_reset();

    // Reset then a single det pulse at ts_q=5
    do_reset();
    while (m_ts != 5) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_ts", 32'(out_ts), 32'd5);
    check("single_level", 32'(level), 32'd1);
    check("single_evt", 32'(evt_cnt), 32'd1);

    // Fill, drop one, then drain in order
    do_reset();
    while (m_ts <= 19) step(m_ts % 4 == 3, 1'b0, 1'b0);
    check("fill_level", 32'(level), 32'd4);
    check("fill_ovf", 32'(ovf), 32'd1);
`ifdef SEQ_LOG_DROPCNT_EN
    check("fill_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    for (int i = 0; i < 4; i++) begin
      check("drain_ts", 32'(out_ts), 32'(3 + 4 * i));
      step(1'b0, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    check("empty_pop_level", 32'(level), 32'd0);

    // ovf clear without a drop, then clear racing a drop
    step(1'b0, 1'b0, 1'b1);
    check("clr_ovf", 32'(ovf), 32'd0);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("clr_vs_drop", 32'(ovf), 32'd1);
    drain_all();

    // Full FIFO with simultaneous push and pop
    do_reset();
    repeat (4) step(1'b1, 1'b0, 1'b0);
    t = m_ts;
    step(1'b1, 1'b1, 1'b0);
    check("pp_level", 32'(level), 32'd4);
    check("pp_ovf", 32'(ovf), 32'd0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    check("pp_fourth", 32'(out_ts), 32'(t));
    drain_all();

    // Timestamp wrap
    while (m_ts != 255) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("wrap_first", 32'(out_ts), 32'd255);
    step(1'b0, 1'b1, 1'b0);
    check("wrap_second", 32'(out_ts), 32'd0);
    drain_all();

    // Asynchronous reset mid-operation with three entries queued
    do_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    check("pre_rst_level", 32'(level), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_level", 32'(level), 32'd0);
    model_reset();
    det = 1'b0;
    out_ready = 1'b0;
    clr_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    check("post_rst_ts", 32'(out_ts), 32'd0);

    // evt_cnt saturation with continuous draining
    do_reset();
    repeat (300) step(1'b1, 1'b1, 1'b0);
    check("evt_sat", 32'(evt_cnt), 32'd255);
    drain_all();

    // Random traffic with occasional asynchronous resets
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
        #1;
        check("rand_rst_level", 32'(level), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
